// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder/subtractor: one nibble pair per clock through a single
// 4-bit adder slice, carry chained through a register, DONE pulses when complete.

module adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign sum  = full[3:0];
    assign cout = full[4];
endmodule

// state  | meaning
// IDLE   | waiting for START, results held
// RUN    | one nibble processed per edge, BUSY high
// DONE_S | one-cycle completion pulse, START accepted as in IDLE
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    input  logic                   SUB,
    input  logic                   CIN,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [4*NIBBLES-1:0]   SUM,
    output logic                   COUT,
    output logic                   OVF,
    output logic                   ZERO
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;

    logic [3:0]      add_a, add_b, add_sum;
    logic            add_cout;
    logic            last_nib;

    assign add_a    = opa_q[{cnt_q, 2'b00} +: 4];
    assign add_b    = opb_q[{cnt_q, 2'b00} +: 4];
    assign last_nib = (cnt_q == CW'(NIBBLES - 1));

    adder_4 u_adder_4 (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE_S: begin
                if (START) begin
                    // subtraction is A + ~B + 1, so the borrow-free case reports COUT=1
                    opa_d   = A;
                    opb_d   = SUB ? ~B : B;
                    carry_d = SUB ? 1'b1 : CIN;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[{cnt_q, 2'b00} +: 4] = add_sum;
                carry_d = add_cout;
                cnt_d   = cnt_q + 1'b1;
                if (last_nib) begin
                    cout_d  = add_cout;
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (add_sum[3] != opa_q[W-1]);
                    zero_d  = (sum_d == '0);
                    state_d = DONE_S;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == DONE_S);
    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
    assign ZERO = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4): directed vectors, busy-time input
// noise, mid-run reset, back-to-back operation and randomized ops vs. a word-level model.

module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;
    localparam int LAT = N + 1;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         START;
    logic         SUB;
    logic         CIN;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         OVF;
    logic         ZERO;

    int checks = 0;
    int failures = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .SUB   (SUB),
        .CIN   (CIN),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT),
        .OVF   (OVF),
        .ZERO  (ZERO)
    );

    always #5 CLK = ~CLK;

    // Word-level reference: unsigned arithmetic for the result and carry/borrow,
    // operand/result signs for overflow.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin,
                                  output logic [W-1:0] s, output logic c,
                                  output logic o, output logic z);
        logic [W:0] full;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            s = full[W-1:0];
            c = (a >= b);
            o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s = full[W-1:0];
            c = full[W];
            o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        z = (s == '0);
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin);
        @(negedge CLK);
        A = a; B = b; SUB = sub; CIN = cin; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = W'($urandom); B = W'($urandom); SUB = 1'($urandom); CIN = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_n, output logic [W-1:0] s,
                             output logic c, output logic o, output logic z);
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (BUSY) busy_n++;
        end while (!DONE && lat < 20);
        s = SUM; c = COUT; o = OVF; z = ZERO;
    endtask

    task automatic test_reset();
        RST_N = 1'b1; START = 1'b0; SUB = 1'b0; CIN = 1'b0; A = '0; B = '0;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, COUT, OVF, ZERO} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b done=%b cout=%b ovf=%b zero=%b want all 0",
                     BUSY, DONE, COUT, OVF, ZERO);
        end
        checks++;
        if (SUM !== '0) begin
            failures++;
            $display("FAIL reset_sum got %h want 0000", SUM);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003, 16'h00FF};
        logic [W-1:0] tb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0F00};
        logic         tsub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic         tcin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [6] = '{16'h5555, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h1000};
        logic [2:0]   ef [6] = '{3'b000, 3'b101, 3'b010, 3'b110, 3'b000, 3'b000};
        int lat, busy_n;
        logic [W-1:0] s;
        logic c, o, z;
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i], tsub[i], tcin[i]);
            wait_done(lat, busy_n, s, c, o, z);
            checks++;
            if (lat != LAT || busy_n != N) begin
                failures++;
                $display("FAIL dir%0d_latency got lat=%0d busy=%0d want lat=%0d busy=%0d",
                         i, lat, busy_n, LAT, N);
            end
            checks++;
            if (s !== es[i]) begin
                failures++;
                $display("FAIL dir%0d_sum got %h want %h", i, s, es[i]);
            end
            checks++;
            if ({c, o, z} !== ef[i]) begin
                failures++;
                $display("FAIL dir%0d_flags got cout/ovf/zero=%b want %b", i, {c, o, z}, ef[i]);
            end
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || SUM !== es[i]) begin
                failures++;
                $display("FAIL dir%0d_hold got done=%b busy=%b sum=%h want 0 0 %h",
                         i, DONE, BUSY, SUM, es[i]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int dones = 0;
        int done_at = 0;
        logic [W-1:0] s_at = '0;
        start_op(16'h00FF, 16'h0F00, 1'b0, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            @(negedge CLK);
            if (DONE) begin
                dones++;
                done_at = n;
                s_at = SUM;
            end
            A = W'($urandom); B = W'($urandom); SUB = 1'($urandom); CIN = 1'($urandom);
            START = (n <= 4) ? 1'($urandom) | n[0] : 1'b0;
        end
        checks++;
        if (dones != 1 || done_at != LAT) begin
            failures++;
            $display("FAIL busy_noise_done got pulses=%0d at=%0d want 1 at %0d", dones, done_at, LAT);
        end
        checks++;
        if (s_at !== 16'h1000 || SUM !== 16'h1000) begin
            failures++;
            $display("FAIL busy_noise_sum got %h/%h want 1000", s_at, SUM);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        int lat, busy_n;
        logic [W-1:0] s;
        logic c, o, z;
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge CLK);
        @(posedge CLK);
        #2;
        checks++;
        if (SUM !== 16'h0005 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL partial_sum got sum=%h busy=%b want 0005 1", SUM, BUSY);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, COUT, OVF, ZERO} !== 5'b0 || SUM !== '0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%h flags=%b want all 0",
                     BUSY, DONE, SUM, {COUT, OVF, ZERO});
        end
        repeat (3) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        RST_N = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (DONE || BUSY) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midrun_no_done got %0d done/busy cycles want 0", dones);
        end
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done(lat, busy_n, s, c, o, z);
        checks++;
        if (lat != LAT || s !== 16'h0002 || {c, o, z} !== 3'b000) begin
            failures++;
            $display("FAIL after_reset_op got lat=%0d sum=%h flags=%b want %0d 0002 000",
                     lat, s, {c, o, z}, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        @(negedge CLK);
        A = 16'h0010; B = 16'h0020; SUB = 1'b0; CIN = 1'b0; START = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= 3 * LAT; n++) begin
            @(negedge CLK);
            if (DONE !== (n % LAT == 0) || BUSY !== (n % LAT != 0)) bad++;
            if (n % LAT == 0 && SUM !== 16'h0030) bad++;
        end
        START = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL back_to_back got %0d bad cycles want 0", bad);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || SUM !== 16'h0030) begin
            failures++;
            $display("FAIL b2b_stop got busy=%b done=%b sum=%h want 0 0 0030", BUSY, DONE, SUM);
        end
    endtask

    task automatic test_random();
        int lat, busy_n;
        logic [W-1:0] a, b, s, es;
        logic sub, cin, c, o, z, ec, eo, ez;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom);
            if (i % 8 == 0) b = a;
            sub = 1'($urandom); cin = 1'($urandom);
            model(a, b, sub, cin, es, ec, eo, ez);
            start_op(a, b, sub, cin);
            wait_done(lat, busy_n, s, c, o, z);
            checks++;
            if (lat != LAT || s !== es || {c, o, z} !== {ec, eo, ez}) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h sub=%b cin=%b got lat=%0d sum=%h flags=%b want lat=%0d sum=%h flags=%b",
                         i, a, b, sub, cin, lat, s, {c, o, z}, LAT, es, {ec, eo, ez});
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
